sdreg_arb: RTL

SDREG_ARB -- requirements
Module: sdreg_arb

---
 rtl/sdreg_arb.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sdreg_arb.sv
`default_nettype none
// ============================================================================
//  Module      : sdreg_arb
//  Description : Single shared register written by NPORTS requesters through
//                a round-robin arbiter. Byte-enabled, RW-masked writes, a
//                one-cycle ack pulse per grant, a combinational busy flag
//                and a saturating collision counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdreg_arb #(
    parameter int               WIDTH   = 16,
    parameter int               NPORTS  = 3,
    parameter logic [WIDTH-1:0] RW_MASK = 16'h7FFF,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NPORTS-1:0]             wr_req,
    input  logic [NPORTS*WIDTH-1:0]       wr_data,
    input  logic [NPORTS*(WIDTH/8)-1:0]   wr_be,
    output logic [NPORTS-1:0]             wr_ack,
    output logic [WIDTH-1:0]              data_out,
    output logic                          busy,
    output logic [7:0]                    coll_cnt
);

    localparam int                 c_NBYTES = WIDTH / 8;
    localparam int                 c_PTR_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic [c_PTR_W:0]   c_NP     = (c_PTR_W + 1)'(NPORTS);

    logic [c_PTR_W-1:0]  r_rr_ptr_q, w_rr_ptr_d;
    logic [WIDTH-1:0]    r_data_q,   w_data_d;
    logic [NPORTS-1:0]   r_ack_q,    w_ack_d;
    logic [7:0]          r_coll_q,   w_coll_d;

    logic [NPORTS-1:0]   w_elig;
    logic [3:0]          w_elig_cnt;
    logic                w_grant_vld;
    logic [c_PTR_W-1:0]  w_grant_idx;
    logic [c_PTR_W:0]    w_scan;
    logic [c_PTR_W:0]    w_ptr_inc;
    logic [c_NBYTES-1:0] w_be_sel;
    logic [WIDTH-1:0]    w_wdata_sel;
    logic [WIDTH-1:0]    w_mask;

    // Eligibility excludes ports being acked now, so a held request cannot
    // be granted twice for one transaction; busy flags two or more contenders.
    always_comb begin
        w_elig     = wr_req & ~r_ack_q;
        w_elig_cnt = '0;
        for (int p = 0; p < NPORTS; p++) begin
            w_elig_cnt = w_elig_cnt + {3'b000, w_elig[p]};
        end
        busy = (w_elig_cnt >= 4'd2);
    end

    // Round-robin search: first eligible port at or above rr_ptr, wrapping.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_scan      = '0;
        for (int k = 0; k < NPORTS; k++) begin
            w_scan = {1'b0, r_rr_ptr_q} + (c_PTR_W + 1)'(k);
            if (w_scan >= c_NP) begin
                w_scan = w_scan - c_NP;
            end
            if (!w_grant_vld && w_elig[w_scan[c_PTR_W-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_scan[c_PTR_W-1:0];
            end
        end
    end

    // Select the granted port's data/byte enables and build the write mask.
    always_comb begin
        w_be_sel    = '0;
        w_wdata_sel = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (w_grant_idx == c_PTR_W'(p)) begin
                w_be_sel    = wr_be[p*c_NBYTES +: c_NBYTES];
                w_wdata_sel = wr_data[p*WIDTH +: WIDTH];
            end
        end
        w_mask = '0;
        for (int b = 0; b < c_NBYTES; b++) begin
            w_mask[b*8 +: 8] = {8{w_be_sel[b]}};
        end
        w_mask = w_mask & RW_MASK;
    end

    // Next-state: masked write, one-hot ack, pointer advance, collision count.
    always_comb begin
        w_data_d   = r_data_q;
        w_ack_d    = '0;
        w_rr_ptr_d = r_rr_ptr_q;
        w_ptr_inc  = {1'b0, w_grant_idx} + (c_PTR_W + 1)'(1);
        if (w_grant_vld) begin
            w_data_d = (r_data_q & ~w_mask) | (w_wdata_sel & w_mask);
            for (int p = 0; p < NPORTS; p++) begin
                w_ack_d[p] = (w_grant_idx == c_PTR_W'(p));
            end
            w_rr_ptr_d = (w_ptr_inc == c_NP) ? '0 : w_ptr_inc[c_PTR_W-1:0];
        end
        w_coll_d = r_coll_q;
        if (busy && (r_coll_q != 8'hFF)) begin
            w_coll_d = r_coll_q + 8'd1;
        end
    end

    // State registers; reset overrides any grant in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_q   <= RST_VAL;
            r_ack_q    <= '0;
            r_rr_ptr_q <= '0;
            r_coll_q   <= '0;
        end else begin
            r_data_q   <= w_data_d;
            r_ack_q    <= w_ack_d;
            r_rr_ptr_q <= w_rr_ptr_d;
            r_coll_q   <= w_coll_d;
        end
    end

    assign wr_ack   = r_ack_q;
    assign data_out = r_data_q;
    assign coll_cnt = r_coll_q;

endmodule
`default_nettype wire
